// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and constants for the data-memory responder.
//   Contents:
//     state_e        responder FSM states (IDLE, WAIT, RESP)
//     err_e          access classification (ERR_NONE, ERR_RANGE, ERR_ALIGN)
//     WAIT_W         width of the wait-state counter
//     BE_W           number of byte lanes in a word
//     classify_addr  range/alignment classification of a byte address
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2
    } err_e;

    // Out-of-range wins over misalignment when both apply; the response is the
    // same either way, the code only matters to whoever inspects it.
    function automatic err_e classify_addr(input logic [31:0] addr,
                                           input int unsigned depth_log2);
        err_e code;
        code = ERR_NONE;
        if ((addr >> (depth_log2 + 2)) != 32'd0) begin
            code = ERR_RANGE;
        end else if (addr[1:0] != 2'b00) begin
            code = ERR_ALIGN;
        end
        return code;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//   Synchronous single-port word array with per-byte write enables.
//   One access per enabled clock edge: the addressed word is read into the
//   output register and, for a write, the enabled byte lanes are updated.
//   A write returns the pre-write contents on rdata_o. Contents are not reset.
//
//   Ports:
//     clk_i    rising-edge clock
//     en_i     perform an access on this edge
//     we_i     1 = write the lanes selected by be_i
//     be_i     byte enables, lane i = bits 8i+7:8i
//     addr_i   word index
//     wdata_i  write data
//     rdata_o  registered read data (updated only on enabled edges)
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [BE_W-1:0]       be_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for a core load/store port. Accepts one request at a
//   time, waits WAIT_CYCLES wait states, performs the access and returns a
//   one-cycle response pulse.
//
//   Handshake: a request transfers on the rising edge where req_valid_i and
//   req_ready_o are both high. req_ready_o is high only in IDLE. There is no
//   response backpressure: rsp_valid_o is a single-cycle pulse in RESP.
//
//   Optional feature macro: DMEM_ERR_CHECK_EN
//     defined   : out-of-range (addr[31:DEPTH_LOG2+2] != 0) or misaligned
//                 (addr[1:0] != 0) accesses respond with rsp_err_o = 1,
//                 rsp_rdata_o = 0 and no store.
//     undefined : rsp_err_o tied 0; addresses alias modulo 2^(DEPTH_LOG2+2).
//
//   Parameters:
//     DEPTH_LOG2   log2 of the word count
//     WAIT_CYCLES  wait states between accept and response (0..15)
//
//   Ports:
//     clk_i, rst_ni            clock, asynchronous active-low reset
//     req_valid_i/req_ready_o  request handshake
//     req_we_i                 1 = store, 0 = load
//     req_addr_i               byte address
//     req_be_i                 store byte enables
//     req_wdata_i              store data
//     rsp_valid_o              one-cycle response pulse
//     rsp_rdata_o              load data (0 for stores, errors, and when idle)
//     rsp_err_o                access error, valid with rsp_valid_o
//     dbg_state_o, dbg_cnt_o   FSM state and wait counter for observation
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [BE_W-1:0]   req_be_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output state_e            dbg_state_o,
    output logic [WAIT_W-1:0] dbg_cnt_o
);

    localparam logic [WAIT_W-1:0] CNT_INIT = WAIT_W'(WAIT_CYCLES);
    localparam bit                NO_WAIT  = (WAIT_CYCLES == 0);

    // Registered state
    state_e            state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [BE_W-1:0]   be_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic              rd_sel_q;

    // Combinational access path
    logic              accept;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [BE_W-1:0]   cur_be;
    logic [31:0]       cur_wdata;
    logic              enter_resp_d;
    err_e              err_d;
    logic              arr_we;
    logic [31:0]       arr_rdata;

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    // With no wait states the access happens on the accept edge itself, before
    // the request has been captured, so in IDLE the array sees the live request.
    assign cur_we    = req_ready_o ? req_we_i    : we_q;
    assign cur_addr  = req_ready_o ? req_addr_i  : addr_q;
    assign cur_be    = req_ready_o ? req_be_i    : be_q;
    assign cur_wdata = req_ready_o ? req_wdata_i : wdata_q;

    // The edge that moves the FSM into RESP is the single edge on which the
    // array is accessed; an abort by reset before that edge leaves memory alone.
    assign enter_resp_d = (accept && NO_WAIT) ||
                          ((state_q == WAIT) && (cnt_q == WAIT_W'(1)));

`ifdef DMEM_ERR_CHECK_EN
    assign err_d = classify_addr(cur_addr, DEPTH_LOG2);
`else
    logic unused_addr_bits;
    assign err_d            = ERR_NONE;
    assign unused_addr_bits = ^{cur_addr[31:DEPTH_LOG2+2], cur_addr[1:0]};
`endif

    assign arr_we = cur_we && (err_d == ERR_NONE);

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (enter_resp_d),
        .we_i    (arr_we),
        .be_i    (cur_be),
        .addr_i  (cur_addr[DEPTH_LOG2+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (arr_rdata)
    );

`ifdef DMEM_ERR_CHECK_EN
    logic rsp_err_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rd_sel_q    <= 1'b0;
`ifdef DMEM_ERR_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= enter_resp_d;
            // Only a clean load exposes array data; stores and errors read 0.
            rd_sel_q    <= enter_resp_d && !cur_we && (err_d == ERR_NONE);
`ifdef DMEM_ERR_CHECK_EN
            rsp_err_q   <= enter_resp_d && (err_d != ERR_NONE);
`endif
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        be_q    <= req_be_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == WAIT_W'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rd_sel_q ? arr_rdata : 32'd0;
`ifdef DMEM_ERR_CHECK_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DL2       = 10;
    localparam int unsigned WA        = 2;   // instance A wait states
    localparam int unsigned WB        = 0;   // instance B wait states
    localparam logic [31:0] MEM_BYTES = 32'd1 << (DL2 + 2);
    localparam int          NB        = 16;  // back-to-back requests on B

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- instance A (WAIT_CYCLES = 2) ----------------
    logic        a_valid, a_ready, a_we, a_rsp_valid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;
    state_e      a_state;
    logic [3:0]  a_cnt;

    dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WA)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
        .req_addr_i(a_addr), .req_be_i(a_be), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata), .rsp_err_o(a_err),
        .dbg_state_o(a_state), .dbg_cnt_o(a_cnt)
    );

    // ---------------- instance B (WAIT_CYCLES = 0) ----------------
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;
    state_e      b_state;
    logic [3:0]  b_cnt;

    dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
        .req_addr_i(b_addr), .req_be_i(b_be), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .rsp_err_o(b_err),
        .dbg_state_o(b_state), .dbg_cnt_o(b_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_a [int unsigned];
    logic [31:0] mem_b [int unsigned];
    logic [32:0] exp_q [$];   // {err, rdata} for instance B

    function automatic bit model_err(input logic [31:0] addr);
`ifdef DMEM_ERR_CHECK_EN
        return (addr >= MEM_BYTES) || ((addr % 4) != 0);
`else
        return (addr != addr);
`endif
    endfunction

    function automatic int unsigned model_idx(input logic [31:0] addr);
        return int'((addr % MEM_BYTES) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    // ---------------- driver for instance A ----------------
    task automatic a_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int unsigned idx;
        int          lat;
        exp_err   = model_err(addr);
        idx       = model_idx(addr);
        exp_rdata = 32'd0;
        if (!we && !exp_err) exp_rdata = mem_a[idx];
        if (we && !exp_err) mem_a[idx] = merge(mem_a.exists(idx) ? mem_a[idx] : 32'hx, wdata, be);
        @(negedge clk);
        check("a_ready_idle", 32'(a_ready), 32'd1);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wdata;
        @(posedge clk); #1;
        // scramble request fields while busy; they must be ignored
        a_valid = 1'b0; a_we = 1'($urandom); a_addr = $urandom; a_be = 4'($urandom); a_wdata = $urandom;
        lat = 0; rdata = 32'd0; err = 1'b0;
        for (int k = 1; k <= int'(WA) + 4; k++) begin
            @(negedge clk);
            if (k == 1) check("a_ready_busy", 32'(a_ready), 32'd0);
            if (a_rsp_valid) begin
                lat = k; rdata = a_rdata; err = a_err;
                break;
            end
        end
        check("a_latency", 32'(lat), 32'(WA + 1));
        check("a_rdata", rdata, exp_rdata);
        check("a_err", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("a_rsp_pulse", 32'(a_rsp_valid), 32'd0);
        check("a_rdata_clear", a_rdata, 32'd0);
        check("a_ready_back", 32'(a_ready), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          pulses;
        int          pops;
        int          ridx;
        logic        r_we    [NB];
        logic [31:0] r_addr  [NB];
        logic [3:0]  r_be    [NB];
        logic [31:0] r_wdata [NB];
        logic [32:0] e;

        rst_n = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_a_err", 32'(a_err), 32'd0);
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_a_state", 32'(a_state), 32'(IDLE));
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        rst_n = 1'b1;

        // fill words 0..15 with known contents
        for (int w = 0; w < 16; w++) a_txn(1'b1, 32'(w * 4), 4'hF, {16'hC0DE, 16'(w)}, rd, er);

        // full-word store and load back
        a_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er);
        a_txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er);
        check("load_deadbeef", rd, 32'hDEADBEEF);

        // partial store: lanes 0 and 2 replaced
        a_txn(1'b1, 32'h14, 4'hF, 32'h11223344, rd, er);
        a_txn(1'b1, 32'h14, 4'b0101, 32'hAABBCCDD, rd, er);
        a_txn(1'b0, 32'h14, 4'h0, 32'h0, rd, er);
        check("load_partial", rd, 32'h11BB33DD);

        // reset while a store waits: no commit, no response
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_be = 4'hF; a_wdata = 32'h55;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wait", 32'(a_state), 32'(WAIT));
        rst_n = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (a_rsp_valid) pulses++;
        end
        check("abort_ready_in_reset", 32'(a_ready), 32'd1);
        check("abort_state_idle", 32'(a_state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_rsp_valid) pulses++;
        end
        check("abort_no_rsp", 32'(pulses), 32'd0);
        a_txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er);
        check("abort_old_data", rd, 32'hC0DE0008);

`ifdef DMEM_ERR_CHECK_EN
        a_txn(1'b0, 32'h1002, 4'h0, 32'h0, rd, er);
        check("err_misaligned_flag", 32'(er), 32'd1);
        check("err_misaligned_rdata", rd, 32'd0);
        a_txn(1'b1, 32'h00001000, 4'hF, 32'h0BADF00D, rd, er);
        check("err_range_flag", 32'(er), 32'd1);
        a_txn(1'b0, 32'h0, 4'h0, 32'h0, rd, er);
        check("err_no_store", rd, 32'hC0DE0000);
`else
        a_txn(1'b1, 32'h00001000, 4'hF, 32'h0BADF00D, rd, er);
        check("alias_store_err", 32'(er), 32'd0);
        a_txn(1'b0, 32'h0, 4'h0, 32'h0, rd, er);
        check("alias_load", rd, 32'h0BADF00D);
        check("alias_load_err", 32'(er), 32'd0);
`endif

        // random traffic on A against the model
        for (int t = 0; t < 30; t++) begin
            logic [31:0] base;
            base = 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 3))
                0: base = base | MEM_BYTES;
                1: base = base + 32'd2;
                2: base = base | 32'h8000_0000;
                default: ;
            endcase
            a_txn(1'($urandom), base, 4'($urandom), $urandom, rd, er);
        end

        // back-to-back stream on B with req_valid held high
        for (int i = 0; i < NB; i++) begin
            if (i < 4) begin
                r_we[i] = 1'b1; r_addr[i] = 32'(i * 4); r_be[i] = 4'hF; r_wdata[i] = $urandom;
            end else begin
                r_we[i]    = 1'($urandom);
                r_addr[i]  = 32'($urandom_range(0, 3) * 4);
                case ($urandom_range(0, 2))
                    0: r_addr[i] = r_addr[i] | MEM_BYTES;
                    1: r_addr[i] = r_addr[i] + 32'd1;
                    default: ;
                endcase
                r_be[i]    = 4'($urandom);
                r_wdata[i] = $urandom;
            end
        end
        @(negedge clk);
        ridx = 0; pops = 0;
        b_valid = 1'b1; b_we = r_we[0]; b_addr = r_addr[0]; b_be = r_be[0]; b_wdata = r_wdata[0];
        for (int c = 0; c < 2 * NB + 4; c++) begin
            if (c > 0) @(negedge clk);
            if (ridx < NB) check("b_ready_toggle", 32'(b_ready), 32'((c % 2) == 0));
            if (b_rsp_valid) begin
                check("b_outstanding", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("b_rdata", b_rdata, e[31:0]);
                    check("b_err", 32'(b_err), 32'(e[32]));
                    pops++;
                end
            end
            if (b_valid && b_ready) begin
                logic        xe;
                int unsigned xi;
                xe = model_err(r_addr[ridx]);
                xi = model_idx(r_addr[ridx]);
                if (!r_we[ridx] && !xe) exp_q.push_back({1'b0, mem_b[xi]});
                else exp_q.push_back({xe, 32'd0});
                if (r_we[ridx] && !xe)
                    mem_b[xi] = merge(mem_b.exists(xi) ? mem_b[xi] : 32'hx, r_wdata[ridx], r_be[ridx]);
                ridx++;
                @(posedge clk); #1;
                if (ridx < NB) begin
                    b_we = r_we[ridx]; b_addr = r_addr[ridx]; b_be = r_be[ridx]; b_wdata = r_wdata[ridx];
                end else begin
                    b_valid = 1'b0;
                end
            end
        end
        check("b_all_accepted", 32'(ridx), 32'(NB));
        check("b_all_responded", 32'(pops), 32'(NB));
        check("b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
